// File: rtl/swu_feeder_pkg.sv
// Shared types and helpers for the SWU raster feeder.
package swu_feeder_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_PAD,
    S_WAIT,
    S_FOLD
  } state_t;

  // Counter width for a range [0, n): never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/swu_fold_serializer.sv
// Holds the accepted pixel and selects one SIMD-wide channel group by fold index.
module swu_fold_serializer
  import swu_feeder_pkg::*;
#(
  parameter int SIMD         = 1,
  parameter int IFMChannels  = 2,
  parameter int IP_PRECISION = 4,
  parameter int FW           = cnt_width(IFMChannels / SIMD)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load,
  input  logic [IFMChannels*IP_PRECISION-1:0] pix_in,
  input  logic [FW-1:0]                       fold,
  output logic [SIMD*IP_PRECISION-1:0]        slice
);

  localparam int EFF = IFMChannels / SIMD;
  localparam int BW  = SIMD * IP_PRECISION;

  logic [IFMChannels*IP_PRECISION-1:0] pix;

  // NOTE: the held pixel is reset too, so nothing from a discarded frame can resurface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix <= '0;
    end else if (load) begin
      pix <= pix_in;
    end
  end

  always_comb begin
    slice = pix[BW-1:0];
    for (int k = 1; k < EFF; k++) begin
      if (fold == FW'(k)) slice = pix[k*BW +: BW];
    end
  end

endmodule

// File: rtl/swu_raster_feeder.sv
// Serializes raster pixels into SIMD-wide folds and inserts zero padding rows/columns.
// Define SWU_FEEDER_TLAST_EN to add op_axis_tlast on the final beat of each padded frame.
module swu_raster_feeder
  import swu_feeder_pkg::*;
#(
  parameter int SIMD           = 1,
  parameter int IFMChannels    = 2,
  parameter int IP_PRECISION   = 4,
  parameter int IFMWidth       = 5,
  parameter int IFMHeight      = 5,
  parameter int PADDING_WIDTH  = 0,
  parameter int PADDING_HEIGHT = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [IFMChannels*IP_PRECISION-1:0] ip_data,
  input  logic                                ip_axis_tvalid,
  output logic                                ip_axis_tready,
  output logic [SIMD*IP_PRECISION-1:0]        op_data,
  output logic                                op_axis_tvalid,
  input  logic                                op_axis_tready
`ifdef SWU_FEEDER_TLAST_EN
  ,
  output logic                                op_axis_tlast
`endif
);

  localparam int EFF_CHANNELS = IFMChannels / SIMD;
  localparam int PW_TOT       = IFMWidth + 2 * PADDING_WIDTH;
  localparam int PH_TOT       = IFMHeight + 2 * PADDING_HEIGHT;
  localparam int RW           = cnt_width(PH_TOT);
  localparam int CW           = cnt_width(PW_TOT);
  localparam int FW           = cnt_width(EFF_CHANNELS);
  localparam int BW           = SIMD * IP_PRECISION;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [FW-1:0] fold;
  logic          running;
  state_t        state;

  logic          adv;
  logic          row_real;
  logic          col_real;
  logic          in_hs;
  logic          load;
  logic          fold_wrap;
  logic          col_wrap;
  logic [BW-1:0] fold_slice;

  assign adv       = !op_axis_tvalid || op_axis_tready;
  assign row_real  = (int'(row) >= PADDING_HEIGHT) && (int'(row) < PADDING_HEIGHT + IFMHeight);
  assign col_real  = (int'(col) >= PADDING_WIDTH) && (int'(col) < PADDING_WIDTH + IFMWidth);
  assign fold_wrap = (fold == FW'(EFF_CHANNELS - 1));
  assign col_wrap  = (col == CW'(PW_TOT - 1));

  // The position counters are the real state; the enum names what they currently mean.
  always_comb begin
    // NOTE: assigning a default first keeps combinational blocks free of inferred latches.
    state = S_RESET;
    if (running) begin
      if (!(row_real && col_real)) state = S_PAD;
      else if (fold == '0)         state = S_WAIT;
      else                         state = S_FOLD;
    end
  end

  assign ip_axis_tready = (state == S_WAIT) && adv;
  assign in_hs          = ip_axis_tready && ip_axis_tvalid;
  assign load           = adv && ((state == S_PAD) || (state == S_FOLD) || in_hs);

  swu_fold_serializer #(
    .SIMD        (SIMD),
    .IFMChannels (IFMChannels),
    .IP_PRECISION(IP_PRECISION),
    .FW          (FW)
  ) u_fold (
    .clk   (clk),
    .reset (reset),
    .load  (in_hs),
    .pix_in(ip_data),
    .fold  (fold),
    .slice (fold_slice)
  );

`ifdef SWU_FEEDER_TLAST_EN
  logic last_pos;
  assign last_pos = (row == RW'(PH_TOT - 1)) && col_wrap && fold_wrap;
`endif

  // NOTE: every register here uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running        <= 1'b0;
      row            <= '0;
      col            <= '0;
      fold           <= '0;
      op_data        <= '0;
      op_axis_tvalid <= 1'b0;
`ifdef SWU_FEEDER_TLAST_EN
      op_axis_tlast  <= 1'b0;
`endif
    end else begin
      running <= 1'b1;

      if (adv) begin
        case (state)
          S_PAD: begin
            op_data        <= '0;
            op_axis_tvalid <= 1'b1;
          end
          S_WAIT: begin
            if (ip_axis_tvalid) begin
              op_data        <= ip_data[BW-1:0];
              op_axis_tvalid <= 1'b1;
            end else begin
              op_axis_tvalid <= 1'b0;
            end
          end
          S_FOLD: begin
            op_data        <= fold_slice;
            op_axis_tvalid <= 1'b1;
          end
          default: ;
        endcase
      end

      // Counters track the next position to load; each load becomes exactly one output beat.
      if (load) begin
`ifdef SWU_FEEDER_TLAST_EN
        op_axis_tlast <= last_pos;
`endif
        if (fold_wrap) begin
          fold <= '0;
          if (col_wrap) begin
            col <= '0;
            row <= (row == RW'(PH_TOT - 1)) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end else begin
          fold <= fold + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_swu_raster_feeder.sv
// Bench for swu_raster_feeder: an unpadded and a 1-pixel-padded 3x3x2 instance driven from a scenario table.
module tb_swu_raster_feeder;

  localparam int W    = 3;
  localparam int H    = 3;
  localparam int CH   = 2;
  localparam int PREC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            rst;
  logic [1:0][CH*PREC-1:0] ip_data;
  logic [1:0]            ip_valid;
  logic [1:0]            ip_ready;
  logic [1:0][PREC-1:0]  op_data;
  logic [1:0]            op_valid;
  logic [1:0]            op_ready;
`ifdef SWU_FEEDER_TLAST_EN
  logic [1:0]            op_last;
`endif

  // Instance 0 has no padding, instance 1 pads one row/column on every side.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    swu_raster_feeder #(
      .SIMD          (1),
      .IFMChannels   (CH),
      .IP_PRECISION  (PREC),
      .IFMWidth      (W),
      .IFMHeight     (H),
      .PADDING_WIDTH (g),
      .PADDING_HEIGHT(g)
    ) dut (
      .clk           (clk),
      .reset         (rst[g]),
      .ip_data       (ip_data[g]),
      .ip_axis_tvalid(ip_valid[g]),
      .ip_axis_tready(ip_ready[g]),
      .op_data       (op_data[g]),
      .op_axis_tvalid(op_valid[g]),
      .op_axis_tready(op_ready[g])
`ifdef SWU_FEEDER_TLAST_EN
      ,
      .op_axis_tlast (op_last[g])
`endif
    );
  end

  typedef struct packed {
    logic [PREC-1:0] data;
    logic            last;
  } beat_t;

  typedef struct {
    int    dut;
    int    frames;
    int    bp_pct;
    int    gap_pct;
    bit    rand_pix;
    int    starve_at;
    bit    partial;
    int    exp_beats;
    string name;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CH*PREC-1:0] pix_q[$];
  beat_t              exp_q[$];

  int first_hs, last_hs, drop_beats, tready_viol;
  bit dropped, resume_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the padded raster; real positions emit the next pixel's channels in order.
  function automatic void build_model(input int pad, input int frames);
    int k;
    int ph;
    int pw;
    k  = 0;
    ph = H + 2 * pad;
    pw = W + 2 * pad;
    exp_q.delete();
    for (int fr = 0; fr < frames; fr++) begin
      for (int r = 0; r < ph; r++) begin
        for (int c = 0; c < pw; c++) begin
          bit is_real;
          is_real = (r >= pad) && (r < pad + H) && (c >= pad) && (c < pad + W);
          for (int f = 0; f < CH; f++) begin
            beat_t b;
            logic [CH*PREC-1:0] p;
            p      = is_real ? pix_q[k] : '0;
            b.data = p[f*PREC +: PREC];
            b.last = (r == ph - 1) && (c == pw - 1) && (f == CH - 1);
            exp_q.push_back(b);
          end
          if (is_real) k++;
        end
      end
    end
  endfunction

  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d]      = 1'b1;
    ip_valid[d] = 1'b0;
    op_ready[d] = 1'b1;
    #1;
    check("rst_op_valid", op_valid[d], 0);
    check("rst_op_data", op_data[d], 0);
    check("rst_ip_ready", ip_ready[d], 0);
`ifdef SWU_FEEDER_TLAST_EN
    check("rst_tlast", op_last[d], 0);
`endif
    repeat (2) @(negedge clk);
    rst[d] = 1'b0;
    #1;
    check("sreset_ip_ready", ip_ready[d], 0);
  endtask

  task automatic run(input vec_t v);
    int d;
    int npix;
    int pi;
    int cyc;
    int beats;
    int starve_cnt;
    int hs_cyc;
    bit acc;
    bit stalled;
    logic [PREC-1:0] held;
    d          = v.dut;
    npix       = v.frames * W * H;
    pi         = 0;
    cyc        = 0;
    beats      = 0;
    starve_cnt = 0;
    hs_cyc     = -10;
    acc        = 1'b0;
    stalled    = 1'b0;
    held       = '0;
    pix_q.delete();
    for (int k = 0; k < npix; k++) begin
      int i;
      i = k % (W * H);
      pix_q.push_back(v.rand_pix ? 16'($urandom) : {8'(i + 8), 8'(i)});
    end
    build_model(d, v.frames);
    first_hs    = -1;
    last_hs     = -1;
    dropped     = 1'b0;
    drop_beats  = -1;
    resume_v    = 1'b0;
    tready_viol = 0;

    while (beats < v.exp_beats && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (acc) ip_valid[d] = 1'b0;
      acc = 1'b0;
      op_ready[d] = (int'($urandom_range(99)) >= v.bp_pct);
      if (!ip_valid[d] && pi < npix) begin
        if (pi == v.starve_at && starve_cnt < 4) begin
          starve_cnt++;
        end else if (int'($urandom_range(99)) >= v.gap_pct) begin
          ip_valid[d] = 1'b1;
          ip_data[d]  = pix_q[pi];
        end
      end
      #1;
      if (cyc == hs_cyc + 1) resume_v = op_valid[d];
      if (d == 1 && ip_ready[d] && beats < 11) tready_viol = 1;
      if (stalled) begin
        check($sformatf("%s_stall_valid", v.name), op_valid[d], 1);
        check($sformatf("%s_stall_data", v.name), op_data[d], held);
      end
      stalled = op_valid[d] && !op_ready[d];
      held    = op_data[d];
      if (beats > 0 && !op_valid[d] && !dropped) begin
        dropped    = 1'b1;
        drop_beats = beats;
      end
      if (op_valid[d] && op_ready[d]) begin
        if (beats < exp_q.size()) begin
          check($sformatf("%s_beat%0d_data", v.name, beats), op_data[d], exp_q[beats].data);
`ifdef SWU_FEEDER_TLAST_EN
          check($sformatf("%s_beat%0d_last", v.name, beats), op_last[d], exp_q[beats].last);
`endif
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        beats++;
      end
      if (ip_valid[d] && ip_ready[d]) begin
        if (pi == v.starve_at) hs_cyc = cyc;
        pi++;
        acc = 1'b1;
      end
    end
    check($sformatf("%s_beat_count", v.name), beats, v.exp_beats);
  endtask

  vec_t vecs[10];

  initial begin
    rst      = 2'b11;
    ip_valid = '0;
    op_ready = '0;
    ip_data  = '0;

    //          dut frm bp  gap rnd starve part beats name
    vecs[0] = '{0,  1,  0,  0,  0,  -1,    0,   18,   "unpadded"};
    vecs[1] = '{1,  1,  0,  0,  0,  -1,    0,   50,   "padded"};
    vecs[2] = '{1,  2,  50, 0,  1,  -1,    0,   100,  "pad_bp"};
    vecs[3] = '{0,  2,  50, 30, 1,  -1,    0,   36,   "nopad_bp_gap"};
    vecs[4] = '{0,  1,  0,  0,  0,  4,     0,   18,   "starve"};
    vecs[5] = '{1,  2,  0,  0,  0,  -1,    0,   100,  "back2back"};
    vecs[6] = '{1,  1,  0,  0,  0,  -1,    1,   7,    "pad_abort"};
    vecs[7] = '{1,  1,  0,  0,  0,  -1,    0,   50,   "pad_after_rst"};
    vecs[8] = '{0,  1,  0,  0,  1,  -1,    1,   7,    "nopad_abort"};
    vecs[9] = '{0,  1,  30, 20, 1,  -1,    0,   18,   "nopad_after_rst"};

    for (int i = 0; i < 10; i++) begin
      do_reset(vecs[i].dut);
      run(vecs[i]);
      if (vecs[i].dut == 1)
        check($sformatf("%s_pad_tready_low", vecs[i].name), tready_viol, 0);
      if (vecs[i].bp_pct == 0 && vecs[i].gap_pct == 0 && vecs[i].starve_at < 0 && !vecs[i].partial)
        check($sformatf("%s_no_bubble_span", vecs[i].name), last_hs - first_hs, vecs[i].exp_beats - 1);
      if (vecs[i].starve_at >= 0) begin
        check("starve_drop_after_beat", drop_beats, CH * vecs[i].starve_at);
        check("starve_resume_next_cycle", resume_v, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
